// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, port ids and payload types for the D-memory arbiter.
// Optional build macro: DMEM_ARB_STATS_EN (per-port transfer counters).
package dmem_arbiter_pkg;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam logic [SW-1:0] STAT_MAX = 16'hFFFF;

  typedef struct packed {
    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_cmd_t;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STAT_MAX) ? v : v + SW'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, the port not served last wins a tie.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    gnt    = 2'b00;
    winner = last;
    unique case (req)
      2'b01: begin
        gnt    = 2'b01;
        winner = PORT_CPU;
      end
      2'b10: begin
        gnt    = 2'b10;
        winner = PORT_LDR;
      end
      2'b11: begin
        if (last == PORT_LDR) begin
          gnt    = 2'b01;
          winner = PORT_CPU;
        end else begin
          gnt    = 2'b10;
          winner = PORT_LDR;
        end
      end
      default: begin
        gnt    = 2'b00;
        winner = last;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port D RAM between controller (port 0) and loader (port 1).
// Optional build macro: DMEM_ARB_STATS_EN enables saturating per-port handshake counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          ram_en,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [SW-1:0] stat_gnt0,
  output logic [SW-1:0] stat_gnt1
);

  logic [1:0] gnt_arb;
  logic [1:0] gnt;
  logic       winner;
  logic       hs;

  logic       last_q, last_d;
  ram_cmd_t   cmd_q, cmd_d;
  logic       rd_v1_q, rd_v1_d;
  logic       rd_p1_q, rd_p1_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;

  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req    ({req1, req0}),
    .last   (last_q),
    .gnt    (gnt_arb),
    .winner (winner)
  );

  // Reset masks the grant so nothing can be accepted while it is asserted.
  assign gnt  = Reset ? 2'b00 : gnt_arb;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign hs   = |gnt;

  // Next state: command register, priority pointer and read tag pipeline.
  always_comb begin
    sel_wr    = (winner == PORT_LDR) ? wr1    : wr0;
    sel_addr  = (winner == PORT_LDR) ? addr1  : addr0;
    sel_wdata = (winner == PORT_LDR) ? wdata1 : wdata0;

    last_d    = last_q;
    cmd_d     = cmd_q;
    cmd_d.en  = 1'b0;
    cmd_d.wr  = 1'b0;
    rd_v1_d   = 1'b0;
    rd_p1_d   = rd_p1_q;

    if (hs) begin
      last_d      = winner;
      cmd_d.en    = 1'b1;
      cmd_d.wr    = sel_wr;
      cmd_d.addr  = sel_addr;
      cmd_d.wdata = sel_wdata;
      rd_v1_d     = ~sel_wr;
      rd_p1_d     = winner;
    end

    rvalid0_d = rd_v1_q & (rd_p1_q == PORT_CPU);
    rvalid1_d = rd_v1_q & (rd_p1_q == PORT_LDR);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q    <= PORT_LDR;
      cmd_q     <= '0;
      rd_v1_q   <= 1'b0;
      rd_p1_q   <= PORT_CPU;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      rd_v1_q   <= rd_v1_d;
      rd_p1_q   <= rd_p1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Masking with Reset cancels a pending write and in-flight reads in the reset cycle.
  assign ram_en    = cmd_q.en & ~Reset;
  assign ram_wr    = cmd_q.wr & ~Reset;
  assign ram_addr  = Reset ? '0 : cmd_q.addr;
  assign ram_wdata = Reset ? '0 : cmd_q.wdata;
  assign rvalid0   = rvalid0_q & ~Reset;
  assign rvalid1   = rvalid1_q & ~Reset;
  assign rdata0    = ram_rdata;
  assign rdata1    = ram_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [SW-1:0] stat_gnt0_q, stat_gnt0_d;
  logic [SW-1:0] stat_gnt1_q, stat_gnt1_d;

  always_comb begin
    stat_gnt0_d = stat_gnt0_q;
    stat_gnt1_d = stat_gnt1_q;
    if (hs && (winner == PORT_CPU)) stat_gnt0_d = sat_inc(stat_gnt0_q);
    if (hs && (winner == PORT_LDR)) stat_gnt1_d = sat_inc(stat_gnt1_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stat_gnt0_q <= '0;
      stat_gnt1_q <= '0;
    end else begin
      stat_gnt0_q <= stat_gnt0_d;
      stat_gnt1_q <= stat_gnt1_d;
    end
  end

  assign stat_gnt0 = Reset ? '0 : stat_gnt0_q;
  assign stat_gnt1 = Reset ? '0 : stat_gnt1_q;
`else
  assign stat_gnt0 = 16'h0;
  assign stat_gnt1 = 16'h0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_dmem_arbiter;

  logic        Clk;
  logic        Reset;
  logic        req0, wr0, req1, wr1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        ram_en, ram_wr;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [15:0] stat_gnt0, stat_gnt1;

  typedef struct {
    logic        port;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] mem [256];

  dmem_arbiter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req0      (req0),
    .wr0       (wr0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .rvalid0   (rvalid0),
    .rdata0    (rdata0),
    .req1      (req1),
    .wr1       (wr1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .rvalid1   (rvalid1),
    .rdata1    (rdata1),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .stat_gnt0 (stat_gnt0),
    .stat_gnt1 (stat_gnt1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single-port RAM with registered read data.
  always @(posedge Clk) begin
    if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic push(input logic port, input logic [15:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every rvalid must match the oldest expected read.
  always @(negedge Clk) begin
    if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        chk("spurious_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_port", 32'({rvalid1, rvalid0}), e.port ? 32'd2 : 32'd1);
        chk("rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h05] = 16'hBEEF;
    mem[8'h20] = 16'hA0A0;
    mem[8'h21] = 16'hB1B1;
    ram_rdata = 16'h0;
    Reset = 1'b1;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) cycle();

    // Reset: requests present but nothing granted, all outputs zero
    req0 = 1; req1 = 1; #1;
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    chk("rst_stats", {stat_gnt1, stat_gnt0}, 32'd0);
    req0 = 0; req1 = 0;
    cycle();
    Reset = 1'b0;

    // Single port-0 read of BEEF
    req0 = 1; wr0 = 0; addr0 = 8'h05; #1;
    chk("t1_gnt", 32'({gnt1, gnt0}), 32'd1);
    push(1'b0, 16'hBEEF);
    cycle();
    req0 = 0;
    chk("t1_ram_en", 32'(ram_en), 32'd1);
    chk("t1_ram_wr", 32'(ram_wr), 32'd0);
    chk("t1_ram_addr", 32'(ram_addr), 32'h05);
    cycle();
    chk("t1_ram_idle", 32'(ram_en), 32'd0);
    chk("t1_addr_hold", 32'(ram_addr), 32'h05);
    cycle();

    // Continuous tie after reset alternates 0,1,0,1
    Reset = 1'b1; cycle(); Reset = 1'b0;
    req0 = 1; wr0 = 0; addr0 = 8'h20;
    req1 = 1; wr1 = 0; addr1 = 8'h21;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt", 32'({gnt1, gnt0}), (i % 2 == 0) ? 32'd1 : 32'd2);
      push((i % 2) != 0, (i % 2 == 0) ? 16'hA0A0 : 16'hB1B1);
      cycle();
      chk("t2_ram_en", 32'(ram_en), 32'd1);
      chk("t2_ram_addr", 32'(ram_addr), (i % 2 == 0) ? 32'h20 : 32'h21);
    end
    req0 = 0; req1 = 0;
    repeat (3) cycle();

    // Port 1 write then port 0 read of the same address next cycle
    req1 = 1; wr1 = 1; addr1 = 8'h10; wdata1 = 16'h1234; #1;
    chk("t3_wgnt", 32'({gnt1, gnt0}), 32'd2);
    cycle();
    req1 = 0;
    req0 = 1; wr0 = 0; addr0 = 8'h10;
    chk("t3_ram_wr", 32'(ram_wr), 32'd1);
    chk("t3_ram_addr", 32'(ram_addr), 32'h10);
    chk("t3_ram_wdata", 32'(ram_wdata), 32'h1234);
    #1;
    chk("t3_rgnt", 32'({gnt1, gnt0}), 32'd1);
    push(1'b0, 16'h1234);
    cycle();
    req0 = 0;
    chk("t3_rd_cmd", 32'({ram_en, ram_wr}), 32'd2);
    repeat (3) cycle();

    // Reset right after a read handshake discards it and re-arms the pointer
    req0 = 1; wr0 = 0; addr0 = 8'h05; #1;
    chk("t4_gnt", 32'({gnt1, gnt0}), 32'd1);
    cycle();
    Reset = 1'b1;
    req0 = 1; req1 = 1; addr1 = 8'h21; #1;
    chk("t4_rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("t4_rst_ram_en", 32'(ram_en), 32'd0);
    cycle();
    Reset = 1'b0; #1;
    chk("t4_tie_gnt", 32'({gnt1, gnt0}), 32'd1);
    push(1'b0, 16'hBEEF);
    req1 = 0;
    cycle();
    req0 = 0;
    repeat (3) cycle();

    // Port 1 alone for 5 cycles
    Reset = 1'b1; cycle(); Reset = 1'b0;
    req1 = 1; wr1 = 0; addr1 = 8'h21;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_gnt", 32'({gnt1, gnt0}), 32'd2);
      push(1'b1, 16'hB1B1);
      cycle();
      chk("t5_ram_en", 32'(ram_en), 32'd1);
    end
    req1 = 0;
`ifdef DMEM_ARB_STATS_EN
    chk("t5_stat1", 32'(stat_gnt1), 32'd5);
    chk("t5_stat0", 32'(stat_gnt0), 32'd0);
`else
    chk("t5_stat1", 32'(stat_gnt1), 32'd0);
    chk("t5_stat0", 32'(stat_gnt0), 32'd0);
`endif
    repeat (3) cycle();

`ifdef DMEM_ARB_STATS_EN
    // Counter saturation
    force dut.stat_gnt0_q = 16'hFFFE;
    #1;
    release dut.stat_gnt0_q;
    chk("t6_preset", 32'(stat_gnt0), 32'hFFFE);
    req0 = 1; wr0 = 1; addr0 = 8'h30; wdata0 = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_sat", 32'(stat_gnt0), 32'hFFFF);
    end
    req0 = 0;
    repeat (2) cycle();
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
